// File: rtl/jtkcpu_mshift_pkg.sv
// Shared types for the KCPU multi-cycle shift/rotate unit: mode codes,
// FSM states and the overflow-mode helper.
package jtkcpu_mshift_pkg;

  typedef enum logic [2:0] {
    MS_LSR  = 3'd0,
    MS_ASR  = 3'd1,
    MS_ASL  = 3'd2,
    MS_RORC = 3'd3,
    MS_ROLC = 3'd4,
    MS_ROR  = 3'd5,
    MS_ROL  = 3'd6,
    MS_RSV  = 3'd7
  } ms_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ms_state_e;

  // Left-moving modes report sign change of the final single-bit step as v
  function automatic logic mode_sets_v(input logic [2:0] m);
    return (m == MS_ASL) || (m == MS_ROLC) || (m == MS_ROL);
  endfunction

endpackage

// File: rtl/jtkcpu_mshift_if.sv
// Sequencer <-> shift unit bundle: request, operand, completion and flags.
interface jtkcpu_mshift_if #(
  parameter int W  = 16,
  parameter int CW = 4
);
  logic          cen;
  logic          start;
  logic          abort;
  logic [2:0]    mode;
  logic          half;
  logic [W-1:0]  din;
  logic [CW-1:0] cnt;
  logic          cin;
  logic          busy;
  logic          done;
  logic [W-1:0]  dout;
  logic          c, v, z, n;

  modport master (
    output cen, start, abort, mode, half, din, cnt, cin,
    input  busy, done, dout, c, v, z, n
  );

  modport slave (
    input  cen, start, abort, mode, half, din, cnt, cin,
    output busy, done, dout, c, v, z, n
  );
endinterface

// File: rtl/jtkcpu_mshift_step.sv
// Combinational single-bit shift/rotate step over the full word or its
// low half; the upper half passes through untouched in half mode.
module jtkcpu_mshift_step
  import jtkcpu_mshift_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] din,
  input  logic         cin,
  input  logic [2:0]   mode,
  input  logic         half,
  output logic [W-1:0] dout,
  output logic         cout,
  output logic         v
);
  localparam int H = W / 2;

  logic         msb, nmsb, right, fill;
  logic [W-1:0] full_res;
  logic [H-1:0] half_res;

  always_comb begin
    msb   = half ? din[H-1] : din[W-1];
    right = 1'b0;
    fill  = 1'b0;
    case (ms_mode_e'(mode))
      MS_LSR:  begin right = 1'b1; fill = 1'b0;   end
      MS_ASR:  begin right = 1'b1; fill = msb;    end
      MS_RORC: begin right = 1'b1; fill = cin;    end
      MS_ROR:  begin right = 1'b1; fill = din[0]; end
      MS_ASL:  begin right = 1'b0; fill = 1'b0;   end
      MS_ROLC: begin right = 1'b0; fill = cin;    end
      MS_ROL:  begin right = 1'b0; fill = msb;    end
      default: begin right = 1'b0; fill = 1'b0;   end
    endcase

    full_res = right ? {fill, din[W-1:1]} : {din[W-2:0], fill};
    half_res = right ? {fill, din[H-1:1]} : {din[H-2:0], fill};

    if (ms_mode_e'(mode) == MS_RSV) begin
      dout = din;
      cout = cin;
    end else begin
      dout = half ? {din[W-1:H], half_res} : full_res;
      cout = right ? din[0] : msb;
    end
    nmsb = half ? dout[H-1] : dout[W-1];
    v    = mode_sets_v(mode) & (msb ^ nmsb);
  end
endmodule

// File: rtl/jtkcpu_mshift.sv
// Multi-cycle shift/rotate unit: accepts an operation in IDLE, shifts up to
// STEP bits per enabled cycle and pulses done with the result and flags.
module jtkcpu_mshift
  import jtkcpu_mshift_pkg::*;
#(
  parameter int W    = 16,
  parameter int CW   = 4,
  parameter int STEP = 1
) (
  input logic             clk,
  input logic             rst_n,
  jtkcpu_mshift_if.slave  bus
);
  ms_state_e     state_reg;
  logic [CW-1:0] rem_reg, rem_next, k;
  logic [W-1:0]  work_reg, dout_reg;
  logic [2:0]    mode_reg;
  logic          half_reg, carry_reg;
  logic          busy_reg, done_reg, c_reg, v_reg, z_reg, n_reg;

  logic [W-1:0]  data_c  [0:STEP];
  logic          carry_c [0:STEP];
  logic          v_c     [0:STEP];

  function automatic logic [1:0] zn(input logic [W-1:0] d, input logic h);
    return h ? {d[W/2-1:0] == '0, d[W/2-1]} : {d == '0, d[W-1]};
  endfunction

  assign data_c[0]  = work_reg;
  assign carry_c[0] = carry_reg;
  assign v_c[0]     = 1'b0;

  // Stage gi is live only while more than gi bits remain; v follows the last live stage
  genvar gi;
  generate
    for (gi = 0; gi < STEP; gi++) begin : g_stage
      logic [W-1:0] sd;
      logic         sc, sv, act;
      jtkcpu_mshift_step #(.W(W)) u_step (
        .din  (data_c[gi]),
        .cin  (carry_c[gi]),
        .mode (mode_reg),
        .half (half_reg),
        .dout (sd),
        .cout (sc),
        .v    (sv)
      );
      assign act           = int'(rem_reg) > gi;
      assign data_c[gi+1]  = act ? sd : data_c[gi];
      assign carry_c[gi+1] = act ? sc : carry_c[gi];
      assign v_c[gi+1]     = act ? sv : v_c[gi];
    end
  endgenerate

  always_comb begin
    k        = (int'(rem_reg) > STEP) ? CW'(STEP) : rem_reg;
    rem_next = rem_reg - k;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      rem_reg   <= '0;
      work_reg  <= '0;
      dout_reg  <= '0;
      mode_reg  <= '0;
      half_reg  <= 1'b0;
      carry_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      c_reg     <= 1'b0;
      v_reg     <= 1'b0;
      z_reg     <= 1'b0;
      n_reg     <= 1'b0;
    end else if (bus.cen) begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            mode_reg  <= bus.mode;
            half_reg  <= bus.half;
            work_reg  <= bus.din;
            carry_reg <= bus.cin;
            if (bus.cnt == '0 || ms_mode_e'(bus.mode) == MS_RSV) begin
              done_reg       <= 1'b1;
              dout_reg       <= bus.din;
              c_reg          <= bus.cin;
              v_reg          <= 1'b0;
              {z_reg, n_reg} <= zn(bus.din, bus.half);
            end else begin
              state_reg <= ST_RUN;
              busy_reg  <= 1'b1;
              rem_reg   <= bus.cnt;
            end
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            rem_reg   <= '0;
          end else begin
            work_reg  <= data_c[STEP];
            carry_reg <= carry_c[STEP];
            rem_reg   <= rem_next;
            if (rem_next == '0) begin
              state_reg      <= ST_IDLE;
              busy_reg       <= 1'b0;
              done_reg       <= 1'b1;
              dout_reg       <= data_c[STEP];
              c_reg          <= carry_c[STEP];
              v_reg          <= v_c[STEP];
              {z_reg, n_reg} <= zn(data_c[STEP], half_reg);
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.dout = dout_reg;
  assign bus.c    = c_reg;
  assign bus.v    = v_reg;
  assign bus.z    = z_reg;
  assign bus.n    = n_reg;
endmodule

// File: tb/tb_jtkcpu_mshift.sv
// Bench for jtkcpu_mshift: STEP=1 and STEP=4 instances share stimulus and are
// checked against an arithmetic reference model of the shift rules.
`timescale 1ns/1ps
module tb_jtkcpu_mshift;
  localparam int W  = 16;
  localparam int CW = 4;
  localparam int H  = W / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cen = 1'b0, start = 1'b0, abort = 1'b0, half = 1'b0, cin = 1'b0;
  logic [2:0]    mode = '0;
  logic [W-1:0]  din = '0;
  logic [CW-1:0] cnt = '0;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] cap_dout1, cap_dout4, pd1, pd4;
  logic         cap_c1, cap_c4, cap_v1, pc1, pc4, anyd;

  jtkcpu_mshift_if #(.W(W), .CW(CW)) b1 ();
  jtkcpu_mshift_if #(.W(W), .CW(CW)) b4 ();

  assign {b1.cen, b1.start, b1.abort, b1.mode, b1.half, b1.din, b1.cnt, b1.cin} =
         {cen, start, abort, mode, half, din, cnt, cin};
  assign {b4.cen, b4.start, b4.abort, b4.mode, b4.half, b4.din, b4.cnt, b4.cin} =
         {cen, start, abort, mode, half, din, cnt, cin};

  jtkcpu_mshift #(.W(W), .CW(CW), .STEP(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  jtkcpu_mshift #(.W(W), .CW(CW), .STEP(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: n shifts of an aw-bit operand, returns {carry, result}
  function automatic logic [W:0] ref_shift(input int md, input logic [W-1:0] a_in,
                                           input logic ci, input int n, input int aw);
    longint unsigned mask, m1, a, x, r, rot;
    longint s;
    int k;
    logic co;
    mask = (64'd1 << aw) - 1;
    m1   = (64'd1 << (aw + 1)) - 1;
    a    = a_in & mask;
    if (n == 0) return {ci, a_in};
    r = 0; co = 1'b0;
    case (md)
      0: begin r = a >> n; co = ((a >> (n - 1)) & 1) != 0; end
      1: begin
        s  = ((a >> (aw - 1)) & 1) != 0 ? longint'(a | ~mask) : longint'(a);
        r  = longint'(s >>> n) & mask;
        co = ((s >>> (n - 1)) & 1) != 0;
      end
      2: begin r = (a << n) & mask; co = (((a << (n - 1)) >> (aw - 1)) & 1) != 0; end
      3, 4: begin
        x   = (longint'(ci) << aw) | a;
        k   = n % (aw + 1);
        rot = (md == 3) ? ((x >> k) | (x << (aw + 1 - k))) & m1
                        : ((x << k) | (x >> (aw + 1 - k))) & m1;
        r   = rot & mask;
        co  = ((rot >> aw) & 1) != 0;
      end
      5: begin
        k  = n % aw;
        r  = ((a >> k) | (a << (aw - k))) & mask;
        co = ((r >> (aw - 1)) & 1) != 0;
      end
      default: begin
        k  = n % aw;
        r  = ((a << k) | (a >> (aw - k))) & mask;
        co = (r & 1) != 0;
      end
    endcase
    return {co, W'(r)};
  endfunction

  task automatic do_op(input int md, input bit hf, input logic [W-1:0] d, input int n,
                       input bit ci, input bit gate, input bit poke, input bit ab);
    int aw, lat1, lat4, edges, seen1, seen4;
    logic [W:0] rr, rp;
    logic [W-1:0] ed;
    logic ec, ev, ez, en;
    aw = hf ? H : W;
    if (n == 0 || md == 7) begin
      ed = d; ec = ci; ev = 1'b0; lat1 = 0; lat4 = 0;
    end else begin
      rr   = ref_shift(md, d, ci, n, aw);
      rp   = ref_shift(md, d, ci, n - 1, aw);
      ec   = rr[W];
      ed   = hf ? {d[W-1:H], rr[H-1:0]} : rr[W-1:0];
      ev   = (md == 2 || md == 4 || md == 6) ? (rp[aw-1] ^ rr[aw-1]) : 1'b0;
      lat1 = n;
      lat4 = (n + 3) / 4;
    end
    ez = hf ? (ed[H-1:0] == '0) : (ed == '0);
    en = ed[aw-1];

    @(negedge clk);
    mode = 3'(md); half = hf; din = d; cnt = CW'(n); cin = ci;
    start = 1'b1; cen = 1'b1; abort = ab;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("busy1_go", b1.busy, lat1 > 0);
    chk("busy4_go", b4.busy, lat4 > 0);
    edges = 0; seen1 = -1; seen4 = -1;
    for (int t = 0; t < 300; t++) begin
      if (b1.done) begin
        if (seen1 < 0) begin
          seen1 = edges;
          chk("res1", {b1.busy, b1.dout, b1.c, b1.v, b1.z, b1.n}, {1'b0, ed, ec, ev, ez, en});
          cap_dout1 = b1.dout; cap_c1 = b1.c; cap_v1 = b1.v;
        end else if (edges > seen1) chk("done1_len", b1.done, 1'b0);
      end
      if (b4.done) begin
        if (seen4 < 0) begin
          seen4 = edges;
          chk("res4", {b4.busy, b4.dout, b4.c, b4.v, b4.z, b4.n}, {1'b0, ed, ec, ev, ez, en});
          cap_dout4 = b4.dout; cap_c4 = b4.c;
        end else if (edges > seen4) chk("done4_len", b4.done, 1'b0);
      end
      if (seen1 >= 0 && seen4 >= 0) break;
      cen = gate ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke && edges == 1 && cen) begin
        start = 1'b1; din = W'($urandom); cnt = CW'($urandom_range(1, 15));
        mode = 3'($urandom_range(0, 6));
      end
      @(negedge clk);
      start = 1'b0;
      if (cen) edges++;
    end
    chk("lat1", seen1, lat1);
    chk("lat4", seen4, lat4);
    cen = 1'b1;
    @(negedge clk);
    chk("done_clr", {b1.done, b4.done}, 2'b00);
    $display("op mode=%0d half=%0d din=%h cnt=%0d cin=%0d gate=%0d poke=%0d -> dout1=%h dout4=%h lat1=%0d lat4=%0d",
             md, hf, d, n, ci, gate, poke, cap_dout1, cap_dout4, seen1, seen4);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst1", {b1.busy, b1.done, b1.dout, b1.c, b1.v, b1.z, b1.n}, '0);
    chk("rst4", {b4.busy, b4.done, b4.dout, b4.c, b4.v, b4.z, b4.n}, '0);
    rst_n = 1'b1;

    do_op(2, 1'b0, 16'h4001, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tp_asl", {cap_dout1, cap_c1, cap_v1}, {16'h0004, 1'b1, 1'b1});
    do_op(3, 1'b1, 16'hAB01, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tp_rorc_half", {cap_dout1, cap_c1}, {16'hAB00, 1'b1});
    do_op(1, 1'b0, 16'h8000, 15, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tp_asr", {cap_dout1, cap_c1}, {16'hFFFF, 1'b0});
    do_op(0, 1'b0, 16'h1234, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("tp_cnt0", {cap_dout1, cap_c1}, {16'h1234, 1'b1});
    do_op(0, 1'b0, 16'hF000, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tp_lsr_step4", {cap_dout4, cap_c4}, {16'h0780, 1'b0});
    do_op(7, 1'b0, 16'h5A5A, 9, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op(6, 1'b0, 16'hC3A5, 11, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op(4, 1'b0, 16'h9001, 13, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op(5, 1'b1, 16'h77E1, 12, 1'b0, 1'b0, 1'b0, 1'b1);

    // abort mid-run, with a start in the same cycle
    @(negedge clk);
    pd1 = b1.dout; pc1 = b1.c; pd4 = b4.dout; pc4 = b4.c;
    mode = 3'd6; half = 1'b0; din = 16'h1357; cnt = 4'd15; cin = 1'b1; start = 1'b1; cen = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_run", {b1.busy, b4.busy}, 2'b11);
    repeat (2) @(negedge clk);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("abort_busy", {b1.busy, b4.busy, b1.done, b4.done}, 4'b0000);
    chk("abort_hold", {b1.dout, b1.c, b4.dout, b4.c}, {pd1, pc1, pd4, pc4});
    anyd = 1'b0;
    repeat (20) begin
      @(negedge clk);
      anyd = anyd | b1.done | b4.done | b1.busy | b4.busy;
    end
    chk("abort_quiet", anyd, 1'b0);
    $display("op abort mid-run -> dout1=%h dout4=%h", b1.dout, b4.dout);

    // asynchronous reset mid-run
    mode = 3'd1; din = 16'h8421; cnt = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid1", {b1.busy, b1.done, b1.dout, b1.c, b1.v, b1.z, b1.n}, '0);
    chk("rst_mid4", {b4.busy, b4.done, b4.dout, b4.c, b4.v, b4.z, b4.n}, '0);
    $display("op reset mid-run -> dout1=%h dout4=%h", b1.dout, b4.dout);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      int n_r;
      n_r = $urandom_range(0, 15);
      do_op($urandom_range(0, 7), 1'($urandom_range(0, 1)), W'($urandom), n_r,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            (n_r >= 5) && ($urandom_range(0, 1) == 1), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
